// File: rtl/axilite_read_channel_if.sv
// AXI4-Lite read-channel bundle (AR/R) shared by master and slave.
// Ports: araddr/arvalid/arready, rdata/rresp/rvalid/rready.
interface axilite_read_channel_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr,
    output arvalid,
    output rready,
    input  arready,
    input  rdata,
    input  rresp,
    input  rvalid
  );

  modport slave (
    input  araddr,
    input  arvalid,
    input  rready,
    output arready,
    output rdata,
    output rresp,
    output rvalid
  );

endinterface

// File: rtl/axilite_read_channel.sv
// AXI4-Lite read slave returning words of the flattened CSR vector.
// Ports: clk, rst (async high), bus (AR/R slave), regs (NUM_REGS x 32).
// Option AXILITE_RD_RANGE_CHECK_EN: SLVERR + zero data past the file.
module axilite_read_channel #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  axilite_read_channel_if.slave   bus,
  input  logic [32*NUM_REGS-1:0]  regs
);

  localparam int IDXW = $clog2(NUM_REGS);

  localparam logic [1:0] OKAY   = 2'b00;
`ifdef AXILITE_RD_RANGE_CHECK_EN
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] LIMIT =
    ADDR_W'(NUM_REGS * 4);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] idx_d;
  logic            arready_q;
  logic            arready_d;
  logic            rvalid_q;
  logic            rvalid_d;
  logic [31:0]     rdata_q;
  logic [31:0]     rdata_d;
  logic [1:0]      rresp_q;
  logic [1:0]      rresp_d;

`ifdef AXILITE_RD_RANGE_CHECK_EN
  logic            oor_q;
  logic            oor_d;
`endif

  logic            ar_hs;
  logic            r_hs;
  logic            unused_addr;

  assign ar_hs = bus.arvalid & arready_q;
  assign r_hs  = rvalid_q & bus.rready;

  // Byte offset and (without range check) upper bits are
  // deliberately dropped from the index.
  assign unused_addr = ^bus.araddr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ar_hs) state_d = FETCH;
      FETCH:   state_d = RESP;
      RESP:    if (r_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    idx_d     = idx_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
`ifdef AXILITE_RD_RANGE_CHECK_EN
    oor_d     = oor_q;
`endif
    unique case (state_q)
      IDLE: begin
        arready_d = ~ar_hs;
        if (ar_hs) begin
          idx_d = bus.araddr[IDXW+1:2];
`ifdef AXILITE_RD_RANGE_CHECK_EN
          oor_d = (bus.araddr >= LIMIT);
`endif
        end
      end
      FETCH: begin
        // Snapshot taken here; RESP holds it.
        rvalid_d = 1'b1;
        rdata_d  = regs[{idx_q, 5'd0} +: 32];
        rresp_d  = OKAY;
`ifdef AXILITE_RD_RANGE_CHECK_EN
        if (oor_q) begin
          rdata_d = 32'h0;
          rresp_d = SLVERR;
        end
`endif
      end
      RESP: begin
        if (r_hs) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // Output / datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= OKAY;
    end else begin
      idx_q     <= idx_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

`ifdef AXILITE_RD_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
    end
  end
`endif

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_axilite_read_channel.sv
// Randomized self-checking bench for axilite_read_channel.
// Reference: word (addr/4) mod NUM_REGS, 2-edge latency, held snapshot.
module tb_axilite_read_channel;

  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [NUM_REGS-1:0][31:0] rf;
  logic [32*NUM_REGS-1:0]    regs;

  int n_chk  = 0;
  int n_fail = 0;

  axilite_read_channel_if #(.ADDR_W(ADDR_W)) bus ();

  assign regs = rf;

  axilite_read_channel #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .regs(regs)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(
    input logic [31:0] a
  );
`ifdef AXILITE_RD_RANGE_CHECK_EN
    if (a >= 32'(NUM_REGS * 4)) return 32'h0;
`endif
    return rf[int'((a >> 2) % NUM_REGS)];
  endfunction

  function automatic logic [1:0] exp_resp(
    input logic [31:0] a
  );
`ifdef AXILITE_RD_RANGE_CHECK_EN
    if (a >= 32'(NUM_REGS * 4)) return 2'b10;
`endif
    return (a == a) ? 2'b00 : 2'b11;
  endfunction

  task automatic set_base();
    rf[0] = 32'h11223344;
    rf[1] = 32'h55667788;
    rf[2] = 32'hDEADBEEF;
    rf[3] = 32'hCAFEF00D;
  endtask

  // One read. wait_n: cycles of rready=0 in RESP.
  // mode: 0 none, 1 zero reg1, 2 random reg writes.
  task automatic rd(
    input logic [31:0] a,
    input int          wait_n,
    input int          mode
  );
    logic [31:0] ed;
    logic [1:0]  er;
    ed = exp_data(a);
    er = exp_resp(a);
    chk("ar_idle", 32'(bus.arready), 32'd1);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    bus.rready  = 1'($urandom_range(1, 0));
    @(posedge clk); #1;
    bus.arvalid = 1'($urandom_range(1, 0));
    bus.araddr  = $urandom;
    chk("ar_drop", 32'(bus.arready), 32'd0);
    chk("rv_early", 32'(bus.rvalid), 32'd0);
    @(posedge clk); #1;
    chk("rv_up", 32'(bus.rvalid), 32'd1);
    chk("rdata", bus.rdata, ed);
    chk("rresp", 32'(bus.rresp), 32'(er));
    chk("ar_fetch", 32'(bus.arready), 32'd0);
    bus.rready = (wait_n == 0);
    for (int i = 0; i < wait_n; i++) begin
      if (mode == 1 && i == 0) rf[1] = 32'h0;
      if (mode == 2)
        rf[$urandom_range(NUM_REGS-1, 0)] = $urandom;
      bus.arvalid = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      chk("rv_hold", 32'(bus.rvalid), 32'd1);
      chk("rd_hold", bus.rdata, ed);
      chk("rr_hold", 32'(bus.rresp), 32'(er));
      chk("ar_block", 32'(bus.arready), 32'd0);
    end
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    @(posedge clk); #1;
    chk("rv_done", 32'(bus.rvalid), 32'd0);
    chk("ar_back", 32'(bus.arready), 32'd1);
    bus.rready = 1'($urandom_range(1, 0));
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    set_base();
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;

    // Reset state.
    #1 rst = 1'b1;
    #2;
    chk("rst_ar", 32'(bus.arready), 32'd0);
    chk("rst_rv", 32'(bus.rvalid), 32'd0);
    chk("rst_rd", bus.rdata, 32'h0);
    chk("rst_rr", 32'(bus.rresp), 32'd0);
    @(posedge clk); #1;
    chk("rst_ar_clk", 32'(bus.arready), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_ar", 32'(bus.arready), 32'd1);

    // Basic, backpressure/snapshot, unaligned, range.
    rd(32'h0, 0, 0);
    rd(32'h4, 5, 1);
    set_base();
    rd(32'h6, 0, 0);
    rd(32'hF, 1, 0);
    rd(32'h10, 0, 0);
    rd(32'h8000_0008, 2, 0);

    // Reset while rvalid is high.
    bus.araddr  = 32'h4;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rv", 32'(bus.rvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rv", 32'(bus.rvalid), 32'd0);
    chk("mid_rst_ar", 32'(bus.arready), 32'd0);
    chk("mid_rst_rd", bus.rdata, 32'h0);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ar", 32'(bus.arready), 32'd1);
    chk("mid_rel_rv", 32'(bus.rvalid), 32'd0);
    @(posedge clk); #1;
    chk("mid_no_beat", 32'(bus.rvalid), 32'd0);
    rd(32'h8, 0, 0);

    // Back-to-back with arvalid and rready high.
    k = 0;
    bus.araddr  = 32'h0;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      chk("b2b_ar", 32'(bus.arready),
          32'(c % 3 == 0));
      chk("b2b_rv", 32'(bus.rvalid),
          32'(c % 3 == 2));
      if (c % 3 == 2)
        chk("b2b_data", bus.rdata,
            exp_data(32'(4 * k)));
      if (c % 3 == 0) begin
        k++;
        bus.araddr = 32'(4 * k);
        if (k == 4) bus.arvalid = 1'b0;
      end
    end

    // Randomized reads.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(3, 0) == 0)
        for (int r = 0; r < NUM_REGS; r++)
          rf[r] = $urandom;
      case ($urandom_range(2, 0))
        0:       a = 32'($urandom_range(15, 0));
        1:       a = 32'($urandom_range(31, 0));
        default: a = $urandom;
      endcase
      for (int g = $urandom_range(2, 0); g > 0; g--) begin
        bus.araddr = $urandom;
        @(posedge clk); #1;
        chk("idle_ar", 32'(bus.arready), 32'd1);
        chk("idle_rv", 32'(bus.rvalid), 32'd0);
      end
      rd(a, $urandom_range(3, 0), $urandom_range(2, 0));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axilite_read_channel.md
Name: axilite_read_channel

Overview:
AXI4-Lite read-channel slave that serves reads of the CSR register file produced by axilite_write_channel.
- Takes the flattened `regs` vector as an input and answers AR/R transactions.
- Sits beside the write channel on the same AXI-Lite port: the write channel owns AW/W/B, this block owns AR/R.
- Gives software read-back of every CSR written via the write channel. Single outstanding transaction.

Parameters:
- NUM_REGS, 4, number of 32-bit CSRs; power of two, minimum 2.
- ADDR_W, 32, width of araddr.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- araddr  in  ADDR_W  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- regs  in  32*NUM_REGS  CSR contents; reg k occupies bits [32k+31:32k].

Behaviour:
- Reset, asynchronous, while rst=1: arready=0, rvalid=0, rdata=0, rresp=2'b00, state=IDLE.
- FSM has three states: IDLE, FETCH, RESP.
- IDLE: arready=1 from the first rising edge after rst deasserts.
  - arvalid&&arready at edge N: latch idx = araddr[$clog2(NUM_REGS)+1:2] (plus the range flag, if the feature is enabled).
  - Same edge: arready<=0, go to FETCH.
- FETCH: one cycle.
  - At edge N+1: rdata <= regs[idx], rresp <= OKAY, rvalid <= 1, go to RESP.
  - So rvalid is first seen high after edge N+1; fixed latency of 2 edges from the AR handshake to R data.
- RESP: rdata and rresp are held stable while rvalid=1, regardless of later changes on `regs` (snapshot taken at the FETCH edge).
  - rvalid&&rready at an edge: rvalid<=0 and arready<=1 at that same edge, go to IDLE.
- Minimum throughput: one read per 3 cycles when rready is tied high.
- araddr[1:0] is ignored; unaligned addresses read the containing word.
- Address bits above the index field are ignored unless the optional feature is enabled.
- arvalid may drop without a handshake: no effect.
- rready high before rvalid: legal, no effect until RESP.
- arvalid is not accepted while in FETCH or RESP (arready=0).
- Reset mid-transaction (FETCH or RESP): outputs go to reset values immediately; the transaction is dropped; no R beat follows.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
Macro: AXILITE_RD_RANGE_CHECK_EN
- Defined:
  - araddr >= NUM_REGS*4 sets an out-of-range flag at AR handshake.
  - In FETCH, rdata <= 32'h0 and rresp <= 2'b10 (SLVERR).
  - Timing and handshake are unchanged.
- Undefined:
  - No range flag logic exists.
  - Upper bits alias: idx wraps modulo NUM_REGS.
  - rresp is always 2'b00.

Test Plan:
- Basic read: regs = {0xCAFEF00D, 0xDEADBEEF, 0x55667788, 0x11223344}, rready tied high; read addr 0 -> rdata=0x11223344, rresp=00, rvalid high exactly 2 edges after the AR handshake, for one cycle.
- Backpressure and snapshot: read addr 4, hold rready=0 for 5 cycles, change reg1 to 0x0 during the wait -> rdata stays 0x55667788 and rvalid stays high until the rready handshake; arready stays 0 throughout.
- Unaligned address: read 0x6 -> 0x55667788. Read 0xF -> 0xCAFEF00D.
- Out-of-range: read 0x10.
  - Macro undefined -> rdata=0x11223344, rresp=00.
  - AXILITE_RD_RANGE_CHECK_EN defined -> rdata=0, rresp=10.
- Reset mid-op: assert rst while rvalid=1 -> rvalid and arready drop without waiting for clk. After release, arready=1 on the next edge; a read of addr 8 returns 0xDEADBEEF.
- Back-to-back: arvalid and rready tied high, addresses 0, 4, 8, 0xC in sequence.
  - Each beat returns the correct word.
  - arready pulses once per 3 cycles.
  - Never more than one outstanding transaction.
